dmi_reqctrl: RTL and testbench
==============================

DMI_REQCTRL -- requirements
Module: dmi_reqctrl

Interface
REQ-001 Parameter abits, default 7, SHALL set the DMI address width.
REQ-002 Parameter timeout_cycles, default 4096, SHALL set the watchdog limit in i_clk cycles; it is used only with DMI_TIMEOUT_EN.
REQ-003 i_clk  in  1  system clock; the block SHALL have this one clock and a synchronous, active-high reset.
REQ-004 i_rst  in  1  synchronous active-high reset.
REQ-005 i_req_toggle  in  1  TCK-domain request toggle; flips once per TAP request.
REQ-006 i_req_write, i_req_addr, i_req_data  in  1/abits/32  request fields; the TAP holds them stable from the toggle until the next toggle.
REQ-007 i_dmi_reset, i_dmi_hardreset  in  1  TCK-domain level pulses from the DTMCONTROL register.
REQ-008 o_dm_req_valid  out  1, i_dm_req_ready  in  1: request handshake toward the Debug Module.
REQ-009 o_dm_write, o_dm_addr, o_dm_wdata  out  1/abits/32: request payload.
REQ-010 i_dm_resp_valid  in  1, i_dm_resp_data  in  32, i_dm_resp_error  in  1: DM response.
REQ-011 o_dm_resp_ready  out  1: response accept.
REQ-012 o_dm_hardreset  out  1: single-cycle hardreset pulse to the DM.
REQ-013 o_resp_data  out  32, o_busy  out  1, o_error  out  1: status fed back to the TAP capture stage.

Function
REQ-014 All async inputs (toggle, dmi_reset, dmi_hardreset) SHALL pass through a 2-flop synchronizer plus an edge register; a request is detected when the synchronized toggle differs from the last registered value, and a reset is detected on the rising edge of the synchronized level.
REQ-015 The FSM SHALL have three states: IDLE, REQ, RESP.
REQ-016 IDLE + request detected: latch the fields into internal registers, go to REQ; the registered fields SHALL drive o_dm_write, o_dm_addr and o_dm_wdata.
REQ-017 REQ: o_dm_req_valid=1; on i_dm_req_ready=1 go to RESP. The payload SHALL stay stable while valid is asserted.
REQ-018 RESP: o_dm_resp_ready=1; on i_dm_resp_valid=1 load o_resp_data from i_dm_resp_data, set sticky error if i_dm_resp_error=1, then go to IDLE.
REQ-019 Latency: the earliest o_dm_req_valid is 4 cycles after the input toggle edge (2 sync, 1 edge, 1 latch).
REQ-020 o_busy SHALL be 1 whenever state != IDLE, OR'd with the sticky busy flag.
REQ-021 A request detected while state != IDLE SHALL be dropped and SHALL set sticky busy.
REQ-022 A dmi_reset edge SHALL clear sticky busy and sticky error, and SHALL NOT change state or o_resp_data.
REQ-023 A dmi_hardreset edge SHALL force IDLE, clear both sticky flags, abandon any outstanding transaction, and pulse o_dm_hardreset for exactly 1 cycle.
REQ-024 Precedence on a simultaneous hardreset, reset and request: hardreset > reset > request; a request coinciding with hardreset is dropped without setting busy.
REQ-025 A write response SHALL still update o_resp_data with i_dm_resp_data.

Reset
REQ-026 On i_rst=1 at a rising edge the block SHALL enter: state=IDLE; sticky flags 0; o_resp_data 0; all DM outputs 0; the synchronizers and edge registers 0; o_dm_hardreset 0. Any transaction in flight is abandoned.

Configuration
REQ-027 With DMI_TIMEOUT_EN defined, a counter SHALL reset on entry to REQ and increment every cycle in REQ/RESP.
REQ-028 When the counter reaches timeout_cycles-1, the block SHALL set sticky error, load o_resp_data=0 and go to IDLE.
REQ-029 Without DMI_TIMEOUT_EN there SHALL be no counter, and the block waits indefinitely.

Structure
REQ-030 The FSM state encoding and the DMI_TIMEOUT default SHALL be defined in the shared dmi package, next to the DMISTAT codes.
REQ-031 A sub-module dmi_sync2 (2-flop synchronizer, 1-bit, with synchronous reset) SHALL be instantiated three times.

Verification
REQ-032 Toggle with write=0, addr=0x11; DM ready immediately; resp data 0xDEADBEEF -> o_dm_req_valid rises 4 cycles after the toggle; o_resp_data=0xDEADBEEF; o_busy back to 0; o_error=0.
REQ-033 Hold i_dm_req_ready=0 for 20 cycles and issue a second toggle -> the second request is dropped, o_busy stays 1 after IDLE, and a dmi_reset edge clears it.
REQ-034 Response with i_dm_resp_error=1 -> o_error=1 until a dmi_reset edge, then 0.
REQ-035 Hardreset edge in RESP -> IDLE next cycle, o_dm_hardreset high for exactly 1 cycle, sticky flags 0.
REQ-036 With DMI_TIMEOUT_EN and timeout_cycles=16, the DM never responds -> IDLE after 16 cycles, o_error=1, o_resp_data=0.
REQ-037 Assert i_rst in REQ -> all outputs 0 and state=IDLE on the next edge; a subsequent toggle is served normally.

Source files
------------

// File: rtl/dmi_reqctrl_pkg.sv
// -----------------------------------------------------------------------------
// dmi_reqctrl_pkg
// Shared DMI definitions: DMISTAT status codes, the request-controller FSM
// state encoding and the default watchdog limit used when DMI_TIMEOUT_EN
// is defined for dmi_reqctrl.
// -----------------------------------------------------------------------------
package dmi_reqctrl_pkg;

  // Default watchdog limit in system-clock cycles.
  localparam int unsigned DMI_TIMEOUT = 4096;

  // DMISTAT codes as reported in the DMI register op field.
  localparam logic [1:0] DMISTAT_OK     = 2'd0;
  localparam logic [1:0] DMISTAT_RSVD   = 2'd1;
  localparam logic [1:0] DMISTAT_FAILED = 2'd2;
  localparam logic [1:0] DMISTAT_BUSY   = 2'd3;

  // Request-controller FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } dmi_state_e;

  // Fold the sticky flags into a DMISTAT code; busy outranks error.
  function automatic logic [1:0] dmistat(input logic busy, input logic error);
    if (busy) begin
      dmistat = DMISTAT_BUSY;
    end else if (error) begin
      dmistat = DMISTAT_FAILED;
    end else begin
      dmistat = DMISTAT_OK;
    end
  endfunction

endpackage

// File: rtl/dmi_sync2.sv
// -----------------------------------------------------------------------------
// dmi_sync2
// Two-flop, 1-bit synchronizer with synchronous active-high reset.
// Ports:
//   i_clk  destination clock
//   i_rst  synchronous active-high reset (clears both stages)
//   i_d    asynchronous input
//   o_q    synchronized output
// -----------------------------------------------------------------------------
module dmi_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  // Two cascaded stages resolve metastability of i_d.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/dmi_reqctrl.sv
// -----------------------------------------------------------------------------
// dmi_reqctrl
// Bridges TAP (TCK-domain) DMI requests into the system clock domain and runs
// the valid/ready handshake with the Debug Module.
// Optional feature: define DMI_TIMEOUT_EN to add a watchdog that abandons a
// transaction after timeout_cycles cycles in REQ/RESP (sets sticky error,
// returns o_resp_data = 0). Without it the block waits indefinitely.
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_req_toggle                      TCK-domain request toggle
//   i_req_write/addr/data             request fields, stable between toggles
//   i_dmi_reset, i_dmi_hardreset      TCK-domain DTMCONTROL levels
//   o_dm_req_valid / i_dm_req_ready   request handshake to the DM
//   o_dm_write/addr/wdata             request payload
//   i_dm_resp_valid/data/error        DM response
//   o_dm_resp_ready                   response accept
//   o_dm_hardreset                    one-cycle hardreset pulse to the DM
//   o_resp_data, o_busy, o_error      status back to the TAP capture stage
// -----------------------------------------------------------------------------
module dmi_reqctrl #(
  parameter int unsigned abits          = 7,
  parameter int unsigned timeout_cycles = dmi_reqctrl_pkg::DMI_TIMEOUT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_toggle,
  input  logic             i_req_write,
  input  logic [abits-1:0] i_req_addr,
  input  logic [31:0]      i_req_data,
  input  logic             i_dmi_reset,
  input  logic             i_dmi_hardreset,
  output logic             o_dm_req_valid,
  input  logic             i_dm_req_ready,
  output logic             o_dm_write,
  output logic [abits-1:0] o_dm_addr,
  output logic [31:0]      o_dm_wdata,
  input  logic             i_dm_resp_valid,
  input  logic [31:0]      i_dm_resp_data,
  input  logic             i_dm_resp_error,
  output logic             o_dm_resp_ready,
  output logic             o_dm_hardreset,
  output logic [31:0]      o_resp_data,
  output logic             o_busy,
  output logic             o_error
);

  import dmi_reqctrl_pkg::*;

  logic tog_sync, rst_sync, hrst_sync;
  logic tog_edge_q, rst_edge_q, hrst_edge_q;
  logic req_pulse_q, rst_pulse_q, hrst_pulse_q;
  logic req_pulse_d, rst_pulse_d, hrst_pulse_d;

  dmi_state_e       state_q, state_d;
  logic             write_q, write_d;
  logic [abits-1:0] addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic             busy_st_q, busy_st_d;
  logic             err_st_q, err_st_d;
  logic             req_valid_q, req_valid_d;
  logic             resp_ready_q, resp_ready_d;
  logic             busy_q, busy_d;
  logic             err_set_s;
  logic             drop_s;
  logic             timeout_hit_s;

  dmi_sync2 u_sync_tog  (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_req_toggle),    .o_q(tog_sync));
  dmi_sync2 u_sync_rst  (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_dmi_reset),     .o_q(rst_sync));
  dmi_sync2 u_sync_hrst (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_dmi_hardreset), .o_q(hrst_sync));

  // Edge detection: any toggle change is a request, reset levels act on rise.
  always_comb begin
    req_pulse_d  = tog_sync ^ tog_edge_q;
    rst_pulse_d  = rst_sync & ~rst_edge_q;
    hrst_pulse_d = hrst_sync & ~hrst_edge_q;
  end

  // Edge registers and registered one-cycle event pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tog_edge_q   <= 1'b0;
      rst_edge_q   <= 1'b0;
      hrst_edge_q  <= 1'b0;
      req_pulse_q  <= 1'b0;
      rst_pulse_q  <= 1'b0;
      hrst_pulse_q <= 1'b0;
    end else begin
      tog_edge_q   <= tog_sync;
      rst_edge_q   <= rst_sync;
      hrst_edge_q  <= hrst_sync;
      req_pulse_q  <= req_pulse_d;
      rst_pulse_q  <= rst_pulse_d;
      hrst_pulse_q <= hrst_pulse_d;
    end
  end

`ifdef DMI_TIMEOUT_EN
  localparam int unsigned CW = (timeout_cycles > 32'd1) ? $clog2(timeout_cycles) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(timeout_cycles - 32'd1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Watchdog count: held at zero in IDLE so it restarts on entry to REQ.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Watchdog counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_hit_s = (cnt_q == CNT_LAST);
`else
  // No watchdog: an unresponsive DM keeps the block waiting.
  assign timeout_hit_s = (timeout_cycles == 32'd0) & 1'b0;
`endif

  // Next-state and datapath. Hardreset outranks dmi_reset, which outranks
  // a request; a request arriving with hardreset is simply lost.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    resp_data_d = resp_data_q;
    busy_st_d   = busy_st_q;
    err_st_d    = err_st_q;
    err_set_s   = 1'b0;
    drop_s      = 1'b0;

    if (hrst_pulse_q) begin
      state_d   = ST_IDLE;
      busy_st_d = 1'b0;
      err_st_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_pulse_q) begin
            write_d = i_req_write;
            addr_d  = i_req_addr;
            wdata_d = i_req_data;
            state_d = ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_REQ: begin
          if (i_dm_req_ready) begin
            state_d = ST_RESP;
          end else if (timeout_hit_s) begin
            err_set_s   = 1'b1;
            resp_data_d = 32'h0000_0000;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_REQ;
          end
        end
        ST_RESP: begin
          if (i_dm_resp_valid) begin
            resp_data_d = i_dm_resp_data;
            err_set_s   = i_dm_resp_error;
            state_d     = ST_IDLE;
          end else if (timeout_hit_s) begin
            err_set_s   = 1'b1;
            resp_data_d = 32'h0000_0000;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_RESP;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
      // A request seen while a transaction is outstanding is discarded.
      drop_s    = req_pulse_q & (state_q != ST_IDLE);
      busy_st_d = ~rst_pulse_q & (busy_st_q | drop_s);
      err_st_d  = ~rst_pulse_q & (err_st_q | err_set_s);
    end

    req_valid_d  = (state_d == ST_REQ);
    resp_ready_d = (state_d == ST_RESP);
    busy_d       = (state_d != ST_IDLE) | busy_st_d;
  end

  // FSM, payload, status and registered handshake outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      write_q      <= 1'b0;
      addr_q       <= {abits{1'b0}};
      wdata_q      <= 32'h0000_0000;
      resp_data_q  <= 32'h0000_0000;
      busy_st_q    <= 1'b0;
      err_st_q     <= 1'b0;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_data_q  <= resp_data_d;
      busy_st_q    <= busy_st_d;
      err_st_q     <= err_st_d;
      req_valid_q  <= req_valid_d;
      resp_ready_q <= resp_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign o_dm_req_valid  = req_valid_q;
  assign o_dm_resp_ready = resp_ready_q;
  assign o_dm_write      = write_q;
  assign o_dm_addr       = addr_q;
  assign o_dm_wdata      = wdata_q;
  assign o_dm_hardreset  = hrst_pulse_q;
  assign o_resp_data     = resp_data_q;
  assign o_busy          = busy_q;
  assign o_error         = err_st_q;

endmodule

// File: tb/tb_dmi_reqctrl.sv
// -----------------------------------------------------------------------------
// tb_dmi_reqctrl
// Directed self-checking bench for dmi_reqctrl. Request payloads and response
// data are queued when stimulus is driven and compared when the DUT presents
// them. The timeout scenario runs only when DMI_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_dmi_reqctrl;

  localparam int AB = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          tog;
  logic          wr;
  logic [AB-1:0] addr;
  logic [31:0]   data;
  logic          dmirst;
  logic          hrst;
  logic          req_ready;
  logic          resp_valid;
  logic [31:0]   resp_data;
  logic          resp_err;

  logic          o_dm_req_valid;
  logic          o_dm_write;
  logic [AB-1:0] o_dm_addr;
  logic [31:0]   o_dm_wdata;
  logic          o_dm_resp_ready;
  logic          o_dm_hardreset;
  logic [31:0]   o_resp_data;
  logic          o_busy;
  logic          o_error;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic          w;
    logic [AB-1:0] a;
    logic [31:0]   d;
  } req_t;

  req_t        req_q[$];
  logic [31:0] resp_q[$];

  always #5 clk = ~clk;

  dmi_reqctrl #(.abits(AB), .timeout_cycles(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_toggle(tog), .i_req_write(wr), .i_req_addr(addr), .i_req_data(data),
    .i_dmi_reset(dmirst), .i_dmi_hardreset(hrst),
    .o_dm_req_valid(o_dm_req_valid), .i_dm_req_ready(req_ready),
    .o_dm_write(o_dm_write), .o_dm_addr(o_dm_addr), .o_dm_wdata(o_dm_wdata),
    .i_dm_resp_valid(resp_valid), .i_dm_resp_data(resp_data), .i_dm_resp_error(resp_err),
    .o_dm_resp_ready(o_dm_resp_ready), .o_dm_hardreset(o_dm_hardreset),
    .o_resp_data(o_resp_data), .o_busy(o_busy), .o_error(o_error)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input logic w, input logic [AB-1:0] a, input logic [31:0] d);
    req_t r;
    wr   = w;
    addr = a;
    data = d;
    tog  = ~tog;
    r.w = w;
    r.a = a;
    r.d = d;
    req_q.push_back(r);
  endtask

  // Toggle that the DUT is expected to discard: nothing is queued.
  task automatic drop_req();
    tog = ~tog;
  endtask

  task automatic wait_valid(input string tag, output int n);
    logic found;
    req_t r;
    found = 1'b0;
    n = 0;
    for (int i = 1; i <= 40 && !found; i++) begin
      tick(1);
      if (o_dm_req_valid) begin
        found = 1'b1;
        n = i;
      end
    end
    check({tag, "_valid_seen"}, {31'd0, found}, 32'd1);
    if (found && req_q.size() > 0) begin
      r = req_q.pop_front();
      check({tag, "_write"}, {31'd0, o_dm_write}, {31'd0, r.w});
      check({tag, "_addr"}, 32'(o_dm_addr), 32'(r.a));
      check({tag, "_wdata"}, o_dm_wdata, r.d);
    end
  endtask

  task automatic wait_idle(input string tag, output int n);
    logic found;
    found = 1'b0;
    n = 0;
    for (int i = 1; i <= 60 && !found; i++) begin
      tick(1);
      if (!o_dm_req_valid && !o_dm_resp_ready) begin
        found = 1'b1;
        n = i;
      end
    end
    check({tag, "_idle_seen"}, {31'd0, found}, 32'd1);
  endtask

  task automatic complete(input string tag, input logic [31:0] d, input logic e);
    int n;
    logic [31:0] exp;
    resp_data  = d;
    resp_err   = e;
    resp_valid = 1'b1;
    resp_q.push_back(d);
    wait_idle(tag, n);
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    exp = resp_q.pop_front();
    check({tag, "_resp_data"}, o_resp_data, exp);
  endtask

  task automatic pulse_dmi_reset();
    dmirst = 1'b1;
    tick(6);
    dmirst = 1'b0;
    tick(4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    int hr_cnt;
    logic seen;

    rst = 1'b1; tog = 1'b0; wr = 1'b0; addr = '0; data = 32'd0;
    dmirst = 1'b0; hrst = 1'b0; req_ready = 1'b0;
    resp_valid = 1'b0; resp_data = 32'd0; resp_err = 1'b0;
    tick(3);
    check("rst_valid", {31'd0, o_dm_req_valid}, 32'd0);
    check("rst_resp_ready", {31'd0, o_dm_resp_ready}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_error", {31'd0, o_error}, 32'd0);
    check("rst_resp_data", o_resp_data, 32'd0);
    check("rst_hardreset", {31'd0, o_dm_hardreset}, 32'd0);
    rst = 1'b0;
    tick(2);

    // Basic read, DM ready immediately.
    req_ready = 1'b1;
    send_req(1'b0, 7'h11, 32'h0000_0000);
    wait_valid("t1", n);
    check("t1_latency", n, 32'd4);
    complete("t1", 32'hDEAD_BEEF, 1'b0);
    check("t1_busy", {31'd0, o_busy}, 32'd0);
    check("t1_error", {31'd0, o_error}, 32'd0);

    // Stalled DM, second toggle dropped, sticky busy.
    req_ready = 1'b0;
    send_req(1'b1, 7'h22, 32'hCAFE_0001);
    wait_valid("t2", n);
    check("t2_latency", n, 32'd4);
    tick(3);
    drop_req();
    tick(17);
    check("t2_valid_held", {31'd0, o_dm_req_valid}, 32'd1);
    check("t2_addr_stable", 32'(o_dm_addr), 32'h22);
    check("t2_wdata_stable", o_dm_wdata, 32'hCAFE_0001);
    req_ready = 1'b1;
    complete("t2", 32'h1234_5678, 1'b0);
    check("t2_busy_sticky", {31'd0, o_busy}, 32'd1);
    tick(8);
    check("t2_no_relaunch", {31'd0, o_dm_req_valid}, 32'd0);
    pulse_dmi_reset();
    check("t2_busy_cleared", {31'd0, o_busy}, 32'd0);
    check("t2_resp_kept", o_resp_data, 32'h1234_5678);

    // Error response, sticky until dmi_reset.
    send_req(1'b0, 7'h33, 32'h0000_0000);
    wait_valid("t3", n);
    complete("t3", 32'hBADC_0DE0, 1'b1);
    check("t3_error_set", {31'd0, o_error}, 32'd1);
    tick(5);
    check("t3_error_held", {31'd0, o_error}, 32'd1);
    pulse_dmi_reset();
    check("t3_error_cleared", {31'd0, o_error}, 32'd0);

    // Hardreset while in RESP with a dropped request pending.
    send_req(1'b0, 7'h44, 32'h0000_0000);
    wait_valid("t4", n);
    tick(1);
    check("t4_in_resp", {31'd0, o_dm_resp_ready}, 32'd1);
    drop_req();
    tick(5);
    hrst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick(1);
      if (o_dm_hardreset) seen = 1'b1;
    end
    check("t4_hardreset_seen", {31'd0, seen}, 32'd1);
    tick(1);
    check("t4_hardreset_1cyc", {31'd0, o_dm_hardreset}, 32'd0);
    check("t4_idle", {31'd0, o_dm_resp_ready}, 32'd0);
    check("t4_busy_clear", {31'd0, o_busy}, 32'd0);
    check("t4_error_clear", {31'd0, o_error}, 32'd0);
    hr_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (o_dm_hardreset) hr_cnt++;
    end
    check("t4_no_extra_pulse", hr_cnt, 32'd0);
    hrst = 1'b0;
    tick(4);

    // Synchronous reset while in REQ, then a normal transaction.
    req_ready = 1'b0;
    send_req(1'b1, 7'h55, 32'h0BAD_F00D);
    wait_valid("t5", n);
    tick(2);
    rst = 1'b1;
    tog = 1'b0;
    tick(1);
    check("t5_valid", {31'd0, o_dm_req_valid}, 32'd0);
    check("t5_resp_ready", {31'd0, o_dm_resp_ready}, 32'd0);
    check("t5_write", {31'd0, o_dm_write}, 32'd0);
    check("t5_addr", 32'(o_dm_addr), 32'd0);
    check("t5_wdata", o_dm_wdata, 32'd0);
    check("t5_resp_data", o_resp_data, 32'd0);
    check("t5_busy", {31'd0, o_busy}, 32'd0);
    check("t5_error", {31'd0, o_error}, 32'd0);
    rst = 1'b0;
    tick(4);
    check("t5_no_spurious", {31'd0, o_dm_req_valid}, 32'd0);
    req_ready = 1'b1;
    send_req(1'b0, 7'h66, 32'h0000_0000);
    wait_valid("t5b", n);
    check("t5b_latency", n, 32'd4);
    complete("t5b", 32'h600D_CAFE, 1'b0);
    check("t5b_busy", {31'd0, o_busy}, 32'd0);

`ifdef DMI_TIMEOUT_EN
    // DM never accepts: watchdog abandons after 16 cycles.
    req_ready = 1'b0;
    send_req(1'b0, 7'h77, 32'h0000_0000);
    wait_valid("t6", n);
    wait_idle("t6", n);
    check("t6_timeout_cycles", n, 32'd16);
    check("t6_error", {31'd0, o_error}, 32'd1);
    check("t6_resp_data", o_resp_data, 32'd0);
    pulse_dmi_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
